// File: rtl/l0_pkg.sv
// l0_pkg: shared FSM encoding, array geometry and drain-mode encodings for the L0 sequencer
package l0_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;
  localparam int L0_ROW = 8;
  localparam int L0_DEPTH = 64;
  localparam logic MODE_ALL = 1'b0;
  localparam logic MODE_STAG = 1'b1;
endpackage

// File: rtl/l0_seq_cnt.sv
// l0_seq_cnt: loadable up-counter with terminal-count flag
// ports: clk, reset (async active-low), ld/d load value, en count enable, lim terminal value, q count, tc = (q == lim)
module l0_seq_cnt #(
  parameter int w = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         en,
  input  logic [w-1:0] d,
  input  logic [w-1:0] lim,
  output logic [w-1:0] q,
  output logic         tc
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (ld) q <= d;
    else if (en) q <= q + 1'b1;
  assign tc = q == lim;
endmodule

// File: rtl/l0_seq.sv
// l0_seq: loads len vectors from activation SRAM into L0, then drains L0 into the PE array
// ports: clk, reset (async active-low); start/mode/base_addr/len command; l0_full/l0_ready L0 status;
//        sram_rd/sram_addr SRAM read port; l0_wr/l0_rd/l0_mode L0 control; busy/done/err status
module l0_seq
  import l0_pkg::*;
#(
  parameter int row    = L0_ROW,
  parameter int addr_w = 11,
  parameter int len_w  = 7,
  parameter int depth  = L0_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [addr_w-1:0] base_addr,
  input  logic [len_w-1:0]  len,
  input  logic              l0_full,
  input  logic              l0_ready,
  output logic              sram_rd,
  output logic [addr_w-1:0] sram_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              l0_mode,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, nxt;
  logic [addr_w-1:0] base_q;
  logic [len_w-1:0] len_q, len_m1, tail_lim, issued, wr_cnt, rd_cnt, tail_cnt;
  logic idle, ok, issue_tc, wr_tc, rd_tc, tail_tc, fin;
  assign idle = state == IDLE;
  assign ok = start && len != '0 && len <= len_w'(depth);
  assign len_m1 = len_q - 1'b1;
  // the tail covers the L0 read register, plus the row stagger in staggered mode
  assign tail_lim = l0_mode == MODE_STAG ? len_w'(row) : len_w'(1);
  assign fin = state == FLUSH && tail_tc && l0_ready;
  always_comb begin
    nxt = idle ? (ok ? LOAD : IDLE)
        : state == LOAD ? (l0_wr && wr_tc ? DRAIN : LOAD)
        : state == DRAIN ? (rd_tc ? FLUSH : DRAIN)
        : (fin ? IDLE : FLUSH);
    sram_rd = state == LOAD && !issue_tc && !l0_full;
    sram_addr = sram_rd ? base_q + addr_w'(issued) : '0;
    l0_rd = state == DRAIN;
    busy = !idle;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      base_q <= '0;
      len_q <= '0;
      l0_mode <= 1'b0;
      l0_wr <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      l0_wr <= sram_rd;
      done <= fin || (idle && start && len == '0);
      err <= idle && start && len > len_w'(depth);
      if (idle && ok) begin
        base_q <= base_addr;
        len_q <= len;
        l0_mode <= mode;
      end
    end
  l0_seq_cnt #(.w(len_w)) u_issue (.clk(clk), .reset(reset), .ld(idle), .en(sram_rd), .d('0), .lim(len_q), .q(issued), .tc(issue_tc));
  // wr_tc marks the write that is the len-th one, so DRAIN begins the cycle after it
  l0_seq_cnt #(.w(len_w)) u_wr (.clk(clk), .reset(reset), .ld(idle), .en(l0_wr), .d('0), .lim(len_m1), .q(wr_cnt), .tc(wr_tc));
  l0_seq_cnt #(.w(len_w)) u_rd (.clk(clk), .reset(reset), .ld(idle), .en(l0_rd), .d('0), .lim(len_m1), .q(rd_cnt), .tc(rd_tc));
  l0_seq_cnt #(.w(len_w)) u_tail (.clk(clk), .reset(reset), .ld(idle), .en(state == FLUSH && !tail_tc), .d('0), .lim(tail_lim), .q(tail_cnt), .tc(tail_tc));
endmodule

// File: tb/tb_l0_seq.sv
// tb_l0_seq: randomized self-checking bench for l0_seq against a precomputed per-command timeline model
module tb_l0_seq;
  localparam int MAXC = 600;
  logic clk = 0, reset = 0, start = 0, mode = 0, l0_full = 0, l0_ready = 0;
  logic [10:0] base_addr = '0;
  logic [6:0] len = '0;
  logic sram_rd, l0_wr, l0_rd, l0_mode, busy, done, err;
  logic [10:0] sram_addr;
  l0_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr), .len(len),
    .l0_full(l0_full), .l0_ready(l0_ready), .sram_rd(sram_rd), .sram_addr(sram_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_mode(l0_mode), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic e_rd[MAXC], e_wr[MAXC], e_l0rd[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC], e_mode[MAXC];
  logic [10:0] e_addr[MAXC];
  logic f_full[MAXC], f_ready[MAXC];
  int cyc = 0, wl = 0, done_cyc = 0, wr_seen = 0, done_seen = 0, first_done = -1;
  bit chk = 0;
  logic prev_mode = 0;
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (chk) begin
    check("sram_rd", sram_rd, e_rd[cyc]);
    if (e_rd[cyc]) check("sram_addr", sram_addr, e_addr[cyc]);
    check("l0_wr", l0_wr, e_wr[cyc]);
    check("l0_rd", l0_rd, e_l0rd[cyc]);
    check("l0_mode", l0_mode, e_mode[cyc]);
    check("busy", busy, e_busy[cyc]);
    check("done", done, e_done[cyc]);
    check("err", err, e_err[cyc]);
    wr_seen += int'(l0_wr);
    done_seen += int'(done);
    if (done && first_done < 0) first_done = cyc;
  end
  // timeline model: cycle 0 carries the start strobe; each later cycle is one clock of the command
  task automatic build(input logic m, input logic [10:0] b, input int n, output int last);
    int iss, k, t, c;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_wr[i] = 0; e_l0rd[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
      e_addr[i] = '0; e_mode[i] = prev_mode;
    end
    if (n == 0 || n > 64) begin
      if (n == 0) e_done[1] = 1;
      else e_err[1] = 1;
      last = 3;
      return;
    end
    iss = 0; k = 1; wl = 0;
    while (iss < n && k < MAXC - 2) begin
      if (!f_full[k]) begin
        e_rd[k] = 1; e_addr[k] = b + 11'(iss); e_wr[k+1] = 1; iss++; wl = k + 1;
      end
      k++;
    end
    for (int i = 1; i <= n; i++) e_l0rd[wl+i] = 1;
    t = m ? 8 : 1;
    c = wl + n + t + 1;
    while (!f_ready[c] && c < MAXC - 4) c++;
    e_done[c+1] = 1;
    for (int i = 1; i <= c; i++) e_busy[i] = 1;
    for (int i = 1; i < MAXC; i++) e_mode[i] = m;
    done_cyc = c + 1;
    last = c + 3;
  endtask
  task automatic run(input logic m, input logic [10:0] b, input int n, input int fm, input int rm, input bit rs);
    int last;
    for (int k = 0; k < MAXC; k++) begin
      f_full[k] = fm == 1 ? ($urandom_range(0, 3) == 0 && k < 150) : (fm == 2 && k >= 11 && k <= 15);
      f_ready[k] = rm == 0 || k >= 320 || $urandom_range(0, 1) == 1;
    end
    build(m, b, n, last);
    wr_seen = 0; done_seen = 0; first_done = -1;
    @(posedge clk); #1;
    for (int k = 0; k <= last; k++) begin
      cyc = k;
      start = k == 0 || (rs && k == wl + 2);
      mode = k == 0 ? m : ~m;
      base_addr = k == 0 ? b : b + 11'h123;
      len = k == 0 ? 7'(n) : 7'd3;
      l0_full = f_full[k];
      l0_ready = f_ready[k];
      chk = 1;
      @(posedge clk); #1;
    end
    chk = 0; start = 0; l0_full = 0;
    if (n >= 1 && n <= 64) prev_mode = m;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_sram_rd", sram_rd, 0); check("rst_l0_wr", l0_wr, 0); check("rst_l0_rd", l0_rd, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_err", err, 0); check("rst_mode", l0_mode, 0);
    reset = 1;
    run(0, 11'h010, 4, 0, 0, 0);
    check("lit_done_cyc_model", done_cyc, 12);
    check("lit_done_cyc_dut", first_done, 12);
    check("lit_addr1", e_addr[1], 11'h010);
    check("lit_addr4", e_addr[4], 11'h013);
    run(1, 11'h100, 8, 0, 1, 0);
    check("stag_done_cnt", done_seen, 1);
    run(0, 11'h200, 64, 2, 0, 0);
    check("stall_wr_cnt", wr_seen, 64);
    check("stall_done_cnt", done_seen, 1);
    run(0, 11'h055, 0, 0, 0, 0);
    check("len0_done_cnt", done_seen, 1);
    run(1, 11'h066, 65, 0, 0, 0);
    check("len65_wr_cnt", wr_seen, 0);
    run(0, 11'h7fe, 4, 0, 0, 0);
    check("wrap_addr3", e_addr[3], 11'h000);
    check("wrap_addr4", e_addr[4], 11'h001);
    run(1, 11'h050, 10, 1, 1, 1);
    check("restart_done_cnt", done_seen, 1);
    check("restart_wr_cnt", wr_seen, 10);
    for (int i = 0; i < 12; i++) begin
      int n = $urandom_range(0, 70);
      run(1'($urandom_range(0, 1)), 11'($urandom), n, $urandom_range(0, 1), $urandom_range(0, 1), n >= 2 && $urandom_range(0, 1) == 1);
      check("rand_done_cnt", done_seen, (n <= 64) ? 1 : 0);
    end
    @(posedge clk); #1;
    start = 1; mode = 1; base_addr = 11'h300; len = 7'd20;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_addr", sram_addr, 11'h305);
    reset = 0;
    #1;
    check("mid_rst_sram_rd", sram_rd, 0); check("mid_rst_addr", sram_addr, 0); check("mid_rst_l0_wr", l0_wr, 0);
    check("mid_rst_l0_rd", l0_rd, 0); check("mid_rst_mode", l0_mode, 0); check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0); check("mid_rst_err", err, 0);
    @(posedge clk); #1;
    reset = 1;
    prev_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/l0_seq.md
Name: l0_seq

Overview:
- Sequencing controller for the 8-row L0 input buffer.
- On a start command it streams `len` activation vectors from activation SRAM into L0, then drains L0 into the PE array using the selected read mode (0 = all rows together, 1 = row-staggered).
- Drives the SRAM read port and L0 wr/rd/mode, and reports busy/done/err to the top-level core controller.

Parameters:
- row, 8, number of L0 rows (PE array height)
- addr_w, 11, activation SRAM address width
- len_w, 7, width of vector-count field
- depth, 64, L0 FIFO depth per row; maximum legal len

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  command strobe; sampled only in IDLE
- mode  input  1  drain mode for this command: 0 = all rows per cycle, 1 = staggered
- base_addr  input  addr_w  first SRAM address of the vector block
- len  input  len_w  number of vectors to load and drain
- l0_full  input  1  L0 o_full
- l0_ready  input  1  L0 o_ready (all rows empty)
- sram_rd  output  1  SRAM read enable, active-high, 1-cycle read latency
- sram_addr  output  addr_w  SRAM read address
- l0_wr  output  1  L0 write strobe
- l0_rd  output  1  L0 read strobe
- l0_mode  output  1  latched mode, held for the whole command
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at command completion
- err  output  1  one-cycle pulse on an illegal command

Behaviour:
- Reset:
  - Asynchronous on reset=0; all outputs 0, FSM goes to IDLE, counters cleared.
  - Reset mid-command aborts immediately; no done is produced.
- FSM states: IDLE, LOAD, DRAIN, FLUSH.
- IDLE:
  - start=1 with 1 ≤ len ≤ depth: latch base_addr, len and mode (l0_mode updates the next cycle); next state LOAD.
  - start=1 with len=0: done pulses next cycle, stay IDLE.
  - start=1 with len>depth: err pulses next cycle, stay IDLE.
  - start while busy: ignored.
- LOAD:
  - Per cycle, if issued<len and l0_full=0: sram_rd=1, sram_addr=base+issued, issued++.
  - l0_wr is sram_rd delayed exactly 1 cycle.
  - l0_full=1 stalls issue (sram_rd=0); in-flight data still writes.
  - Address arithmetic is modulo 2^addr_w (wraps at 2047→0).
  - LOAD→DRAIN in the cycle after the len-th l0_wr pulse. l0_wr and l0_rd are never high in the same cycle.
- DRAIN:
  - l0_rd=1 for exactly len consecutive cycles, then go to FLUSH.
  - No stall in DRAIN; the PE array always accepts.
- FLUSH:
  - Wait a tail count: mode 0 → 1 cycle; mode 1 → row cycles. This covers the L0 rd_en register and the stagger shift.
  - After the tail expires, stay until l0_ready=1.
  - Then done=1 for one cycle and go to IDLE (busy=0 in the same cycle done is high).
- Latency: mode 0 with no stalls, start to done = 1 + (len+1) + len + 1 + 1 cycles. Bench checks against this formula, ±0.
- Simultaneous start and done cycle: start is ignored because the FSM is not yet in IDLE.

Decomposition:
- Shared package l0_pkg holds:
  - state encoding: IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, FLUSH=2'd3
  - constants L0_ROW=8 and L0_DEPTH=64
  - mode encodings MODE_ALL=1'b0, MODE_STAG=1'b1
- One natural sub-module: l0_seq_cnt, a loadable up-counter with terminal-count flag. It is instantiated for the issue count, write count, drain count and tail count.

Test Plan:
- Reset mid-LOAD: reset=0 at issued=5 → all outputs 0 within the same cycle. After release, FSM is in IDLE and busy=0 with no done.
- Mode 0 basic: start, len=4, base=0x010, mode=0 → sram_addr 0x010..0x013 on 4 consecutive cycles; l0_wr pulses 1 cycle later; l0_rd high 4 cycles; done arrives 12 cycles after start.
- Mode 1 stagger: len=8, mode=1 → l0_mode=1 throughout; after 8 l0_rd cycles, done is not earlier than 8 tail cycles later and only with l0_ready=1.
- Full stall: len=64, force l0_full=1 for cycles 10–14 of LOAD → sram_rd=0 during the stall; total l0_wr pulses=64; addresses contiguous with none skipped or repeated.
- Illegal/edge commands:
  - len=0 → done one cycle later, busy stays 0.
  - len=65 → err pulse, no sram_rd.
  - base=0x7FE, len=4 → addresses 0x7FE, 0x7FF, 0x000, 0x001.
- start while busy: second start during DRAIN with different base → ignored; first command completes unchanged with a single done pulse.
